// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Groups every decode-side, forwarding and execute-side signal of the ID/EX
// pipeline register into one bundle. Clock and reset stay outside.
//   master : drives decode fields, en/flush and the MEM/WB forwarding sources;
//            receives the ALU operands, pass-through controls and hazard_stall.
//   slave  : the id_ex_stage itself (mirror of master).
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
  logic        en;
  logic        flush;

  logic [3:0]  id_aluop;
  logic [1:0]  id_alusrc;
  logic [31:0] id_rdat1;
  logic [31:0] id_rdat2;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wsel;
  logic        id_regwen;
  logic        id_memread;
  logic        id_memwrite;

  logic        mem_regwen;
  logic [4:0]  mem_wsel;
  logic [31:0] mem_result;
  logic        wb_regwen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_result;

  logic [3:0]  ex_aluop;
  logic [31:0] ex_pA;
  logic [31:0] ex_pB;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wsel;
  logic        ex_regwen;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        hazard_stall;

  modport master (
    output en, flush,
    output id_aluop, id_alusrc, id_rdat1, id_rdat2, id_imm, id_shamt,
    output id_rs, id_rt, id_wsel, id_regwen, id_memread, id_memwrite,
    output mem_regwen, mem_wsel, mem_result, wb_regwen, wb_wsel, wb_result,
    input  ex_aluop, ex_pA, ex_pB, ex_store_data, ex_wsel,
    input  ex_regwen, ex_memread, ex_memwrite, hazard_stall
  );

  modport slave (
    input  en, flush,
    input  id_aluop, id_alusrc, id_rdat1, id_rdat2, id_imm, id_shamt,
    input  id_rs, id_rt, id_wsel, id_regwen, id_memread, id_memwrite,
    input  mem_regwen, mem_wsel, mem_result, wb_regwen, wb_wsel, wb_result,
    output ex_aluop, ex_pA, ex_pB, ex_store_data, ex_wsel,
    output ex_regwen, ex_memread, ex_memwrite, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Captures the decoded instruction, forwards MEM/WB
// results into the rs/rt operands, selects the ALU operands, detects load-use
// hazards (inserting a bubble) and honours flush and memory-stall hold.
// Ports:
//   CLK  : rising-edge clock
//   nRST : asynchronous active-low reset (state becomes a bubble)
//   bus  : id_ex_stage_if.slave - decode inputs, en/flush, MEM/WB forwarding
//          sources, ALU operands, pass-through controls, hazard_stall
// ---------------------------------------------------------------------------
module id_ex_stage (
  input logic          CLK,
  input logic          nRST,
  id_ex_stage_if.slave bus
);

  // All registered fields in one word so a bubble is simply '0.
  typedef struct packed {
    logic [3:0]  aluop;
    logic [1:0]  alusrc;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wsel;
    logic        regwen;
    logic        memread;
    logic        memwrite;
  } ex_fields_t;

  ex_fields_t  state_q;
  ex_fields_t  state_d;
  ex_fields_t  id_fields;
  logic        hazard;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // MEM has priority over WB; register 0 is never forwarded.
  function automatic logic [31:0] forward_src(
    input logic [4:0]  src,
    input logic [31:0] rdat,
    input logic        m_wen,
    input logic [4:0]  m_sel,
    input logic [31:0] m_res,
    input logic        w_wen,
    input logic [4:0]  w_sel,
    input logic [31:0] w_res
  );
    logic [31:0] val;
    val = rdat;
    if (m_wen && (m_sel == src) && (src != 5'd0)) begin
      val = m_res;
    end else if (w_wen && (w_sel == src) && (src != 5'd0)) begin
      val = w_res;
    end
    return val;
  endfunction

  // Gather the decode-side fields into the register layout.
  always_comb begin
    id_fields          = '0;
    id_fields.aluop    = bus.id_aluop;
    id_fields.alusrc   = bus.id_alusrc;
    id_fields.rdat1    = bus.id_rdat1;
    id_fields.rdat2    = bus.id_rdat2;
    id_fields.imm      = bus.id_imm;
    id_fields.shamt    = bus.id_shamt;
    id_fields.rs       = bus.id_rs;
    id_fields.rt       = bus.id_rt;
    id_fields.wsel     = bus.id_wsel;
    id_fields.regwen   = bus.id_regwen;
    id_fields.memread  = bus.id_memread;
    id_fields.memwrite = bus.id_memwrite;
  end

  // Load-use: the load in EX writes a register the instruction in ID reads.
  // rt is compared even for I-type instructions (conservative stall).
  always_comb begin
    hazard = state_q.memread && (state_q.wsel != 5'd0) &&
             ((state_q.wsel == bus.id_rs) || (state_q.wsel == bus.id_rt));
  end

  // Next state: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = '0;
    end else if (!bus.en) begin
      state_d = state_q;
    end else if (hazard) begin
      state_d = '0;
    end else begin
      state_d = id_fields;
    end
  end

  // Pipeline register with asynchronous clear to a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Forwarding and operand select. With alusrc 10 the ALU shifts pA by pB,
  // so the rt value moves to pA and the shift amount to pB.
  always_comb begin
    fwd_a = forward_src(state_q.rs, state_q.rdat1, bus.mem_regwen, bus.mem_wsel,
                        bus.mem_result, bus.wb_regwen, bus.wb_wsel, bus.wb_result);
    fwd_b = forward_src(state_q.rt, state_q.rdat2, bus.mem_regwen, bus.mem_wsel,
                        bus.mem_result, bus.wb_regwen, bus.wb_wsel, bus.wb_result);
    case (state_q.alusrc)
      2'b01: begin
        bus.ex_pA = fwd_a;
        bus.ex_pB = state_q.imm;
      end
      2'b10: begin
        bus.ex_pA = fwd_b;
        bus.ex_pB = {27'b0, state_q.shamt};
      end
      default: begin
        bus.ex_pA = fwd_a;
        bus.ex_pB = fwd_b;
      end
    endcase
  end

  assign bus.ex_store_data = fwd_b;
  assign bus.ex_aluop      = state_q.aluop;
  assign bus.ex_wsel       = state_q.wsel;
  assign bus.ex_regwen     = state_q.regwen;
  assign bus.ex_memread    = state_q.memread;
  assign bus.ex_memwrite   = state_q.memwrite;
  assign bus.hazard_stall  = hazard;

endmodule
